// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file defaults and the named registers the
// old fixed debug outputs used to expose.
package cpu_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    localparam int R_T0 = 8;
    localparam int R_S0 = 16;
    localparam int R_S1 = 17;
    localparam int R_S2 = 18;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: stored value and busy flag in, with optional
// same-cycle write forwarding and hard-wired zero register.
module rf_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clr,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] stored_q,
    input  logic              stored_busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rq,
    output logic              rbusy
);

    // The late port is checked first so a forwarded value matches what the
    // register will hold after the edge.
    always_comb begin
        rq    = stored_q;
        rbusy = stored_busy;
        if (BYPASS != 0) begin
            if (we1 && (wa1 == ra)) begin
                rq    = wd1;
                rbusy = 1'b0;
            end else if (we0 && (wa0 == ra)) begin
                rq    = wd0;
                rbusy = 1'b0;
            end
        end
        if (!clr || (ra == '0)) begin
            rq    = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-port register file with two write ports, a per-register busy
// scoreboard for hazard stalls, and an unbypassed debug tap.
module rf_multiport_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        sa,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rq,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic [ADDR_W-1:0]        dbg_sel,
    output logic [DATA_W-1:0]        dbg_q
);

    localparam int DEPTH = 2 ** ADDR_W;

    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_num_rd_check
        $error("rf_multiport_sb: NUM_RD must be in 1..4");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Port 1 is written after port 0, so on a same-address collision the
    // younger long-latency result wins over the older WB result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (we0 && (wa0 != REG_ZERO[ADDR_W-1:0])) begin
                regs[wa0] <= wd0;
            end
            if (we1 && (wa1 != REG_ZERO[ADDR_W-1:0])) begin
                regs[wa1] <= wd1;
            end
        end
    end

    // Set is applied last: a freshly issued producer outranks a retiring one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy <= '0;
        end else begin
            if (we0) begin
                busy[wa0] <= 1'b0;
            end
            if (we1) begin
                busy[wa1] <= 1'b0;
            end
            if (set_busy && (sa != REG_ZERO[ADDR_W-1:0])) begin
                busy[sa] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_port (
            .clr         (clr),
            .ra          (ra[i*ADDR_W +: ADDR_W]),
            .stored_q    (regs[ra[i*ADDR_W +: ADDR_W]]),
            .stored_busy (busy[ra[i*ADDR_W +: ADDR_W]]),
            .we0         (we0),
            .wa0         (wa0),
            .wd0         (wd0),
            .we1         (we1),
            .wa1         (wa1),
            .wd1         (wd1),
            .rq          (rq[i*DATA_W +: DATA_W]),
            .rbusy       (rbusy[i])
        );
    end

    assign dbg_q = regs[dbg_sel];

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed bench: one bypassing and one non-bypassing four-port instance
// driven by the same stimulus, checked against hand-computed values.
module tb_rf_multiport_sb;
    import cpu_pkg::*;

    logic        clk;
    logic        clr;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        set_busy;
    logic [4:0]  sa;
    logic [19:0] ra;
    logic [4:0]  dbg_sel;

    logic [127:0] rq_b;
    logic [3:0]   rbusy_b;
    logic [31:0]  dbg_b;
    logic [127:0] rq_n;
    logic [3:0]   rbusy_n;
    logic [31:0]  dbg_n;

    int vectors;
    int miscompares;

    rf_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1)) dut_b (
        .clk(clk), .clr(clr),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .set_busy(set_busy), .sa(sa),
        .ra(ra), .rq(rq_b), .rbusy(rbusy_b),
        .dbg_sel(dbg_sel), .dbg_q(dbg_b)
    );

    rf_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(0)) dut_n (
        .clk(clk), .clr(clr),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .set_busy(set_busy), .sa(sa),
        .ra(ra), .rq(rq_n), .rbusy(rbusy_n),
        .dbg_sel(dbg_sel), .dbg_q(dbg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane(input logic [127:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic sb, input logic [4:0] s);
        we0 = w0; wa0 = a0; wd0 = d0;
        we1 = w1; wa1 = a1; wd1 = d1;
        set_busy = sb; sa = s;
        #1;
    endtask

    task automatic setRa(input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3);
        ra = {a3, a2, a1, a0};
        #1;
    endtask

    // Commit on the next rising edge, then return to idle inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr     = 1'b0;
        dbg_sel = 5'd0;
        ra      = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #12;
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Basic writes and same-cycle visibility
        setRa(5'd4, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd4, 32'h04, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("byp_r4_same", lane(rq_b, 0), 32'h04);
        checkOutput("nobyp_r4_same", lane(rq_n, 0), 32'h00);
        tick();
        checkOutput("nobyp_r4_next", lane(rq_n, 0), 32'h04);

        setRa(5'd5, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd5, 32'h05, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("nobyp_r5_same", lane(rq_n, 0), 32'h00);
        tick();
        checkOutput("nobyp_r5_next", lane(rq_n, 0), 32'h05);

        applyStimulus(1'b1, R_T0[4:0], 32'h08, 1'b1, R_S0[4:0], 32'h10, 1'b0, 5'd0);
        dbg_sel = R_T0[4:0];
        #1;
        checkOutput("dbg_not_bypassed", dbg_b, 32'h00);
        tick();
        checkOutput("dbg_r8", dbg_n, 32'h08);
        dbg_sel = R_S0[4:0];
        #1;
        checkOutput("dbg_r16", dbg_b, 32'h10);

        // All four ports at once, two sharing an address
        setRa(5'd4, 5'd5, R_T0[4:0], 5'd4);
        checkOutput("mp_b_p0", lane(rq_b, 0), 32'h04);
        checkOutput("mp_b_p1", lane(rq_b, 1), 32'h05);
        checkOutput("mp_b_p2", lane(rq_b, 2), 32'h08);
        checkOutput("mp_b_p3", lane(rq_b, 3), 32'h04);
        checkOutput("mp_n_p2", lane(rq_n, 2), 32'h08);
        checkOutput("mp_n_p3", lane(rq_n, 3), 32'h04);

        // Mark R5 busy so the reset check has something to clear
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        tick();
        checkOutput("busy_r5_set", {31'd0, rbusy_n[1]}, 32'h1);

        // Asynchronous reset mid-cycle, held across an edge
        dbg_sel = 5'd4;
        #2;
        clr = 1'b0;
        #1;
        checkOutput("rst_async_rq", lane(rq_n, 0), 32'h00);
        checkOutput("rst_async_dbg", dbg_n, 32'h00);
        checkOutput("rst_async_rbusy", {28'd0, rbusy_b}, 32'h0);
        applyStimulus(1'b1, 5'd4, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("rst_held_byp", lane(rq_b, 0), 32'h00);
        @(posedge clk);
        #3;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_rel_rq", lane(rq_n, 0), 32'h00);
        checkOutput("rst_rel_rq3", lane(rq_b, 3), 32'h00);
        checkOutput("rst_rel_dbg", dbg_b, 32'h00);
        checkOutput("rst_rel_rbusy", {28'd0, rbusy_n}, 32'h0);

        // Dual write to one register: the late port wins
        setRa(R_S1[4:0], 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, R_S1[4:0], 32'h11, 1'b1, R_S1[4:0], 32'h22, 1'b0, 5'd0);
        checkOutput("prio_byp_same", lane(rq_b, 0), 32'h22);
        checkOutput("prio_nobyp_same", lane(rq_n, 0), 32'h00);
        tick();
        checkOutput("prio_b_next", lane(rq_b, 0), 32'h22);
        checkOutput("prio_n_next", lane(rq_n, 0), 32'h22);
        dbg_sel = R_S1[4:0];
        #1;
        checkOutput("prio_dbg", dbg_n, 32'h22);

        // Register zero ignores writes and set_busy
        setRa(5'd0, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        checkOutput("r0_byp_same", lane(rq_b, 0), 32'h00);
        tick();
        checkOutput("r0_b_next", lane(rq_b, 0), 32'h00);
        checkOutput("r0_rbusy", {28'd0, rbusy_b}, 32'h0);
        dbg_sel = 5'd0;
        #1;
        checkOutput("r0_dbg", dbg_n, 32'h00);

        // Scoreboard set, clear via late port, and set-beats-clear
        setRa(R_S2[4:0], 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, R_S2[4:0]);
        checkOutput("sb_set_same", {31'd0, rbusy_b[0]}, 32'h0);
        tick();
        checkOutput("sb_set_b_next", {31'd0, rbusy_b[0]}, 32'h1);
        checkOutput("sb_set_n_next", {31'd0, rbusy_n[0]}, 32'h1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, R_S2[4:0], 32'h12, 1'b0, 5'd0);
        checkOutput("sb_clr_b_busy", {31'd0, rbusy_b[0]}, 32'h0);
        checkOutput("sb_clr_b_rq", lane(rq_b, 0), 32'h12);
        checkOutput("sb_clr_n_busy", {31'd0, rbusy_n[0]}, 32'h1);
        checkOutput("sb_clr_n_rq", lane(rq_n, 0), 32'h00);
        tick();
        checkOutput("sb_after_b_busy", {31'd0, rbusy_b[0]}, 32'h0);
        checkOutput("sb_after_n_busy", {31'd0, rbusy_n[0]}, 32'h0);
        checkOutput("sb_after_n_rq", lane(rq_n, 0), 32'h12);
        applyStimulus(1'b1, R_S2[4:0], 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, R_S2[4:0]);
        tick();
        checkOutput("sb_setwins_b", {31'd0, rbusy_b[0]}, 32'h1);
        checkOutput("sb_setwins_n", {31'd0, rbusy_n[0]}, 32'h1);
        checkOutput("sb_setwins_rq", lane(rq_n, 0), 32'h33);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
